// File: rtl/cpu_pkg.sv
// Shared definitions for the multiplier operand stage.
//   DATA_W   : register / operand width
//   ADDR_W   : register address width (2**ADDR_W registers)
//   MULT_LAT : cycles the external multiplier needs to settle (>= 1)
//   mul_state_t : operand-stage FSM states
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int MULT_LAT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WB   = 2'd2
    } mul_state_t;

endpackage

// File: rtl/reg_array_8x8.sv
// Register file storage.
//   clk, rst_n            : clock, asynchronous active-low clear of all entries
//   we_a/waddr_a/wdata_a  : general write port
//   we_b/waddr_b/wdata_b  : writeback port, wins over port A on the same address
//   raddr1/2 -> rdata1/2  : combinational read ports (no write bypass)
//   raddr3/4 -> rdata3/4  : combinational operand read ports
module reg_array_8x8 import cpu_pkg::*; #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] waddr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] waddr_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic [ADDR_W-1:0] raddr3,
    input  logic [ADDR_W-1:0] raddr4,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] rdata3,
    output logic [DATA_W-1:0] rdata4
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREG];
    logic              a_blocked;

    // Port B has fixed priority: a colliding port A write is dropped.
    assign a_blocked = we_b && (waddr_a == waddr_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we_a && !a_blocked) begin
                mem[waddr_a] <= wdata_a;
            end
            if (we_b) begin
                mem[waddr_b] <= wdata_b;
            end
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
    assign rdata3 = mem[raddr3];
    assign rdata4 = mem[raddr4];

endmodule

// File: rtl/mul_operand_stage.sv
// Operand stage in front of a combinational multiplier.
//   CLK, RESET_N                : clock, asynchronous active-low reset
//   WRITE/WRITEREG/WRITEDATA    : general register write
//   READREG1/2 -> REGOUT1/2     : combinational register reads
//   MUL_START, MUL_SRC1/2, MUL_DEST : multiply request (sampled at CLK edge)
//   MUL_BUSY, MUL_DONE          : handshake (busy in WAIT/WB, done in WB)
//   MULTIPLICAND, MULTIPLIER    : registered operands to the multiplier
//   PRODUCT                     : multiplier result, written back in WB
module mul_operand_stage import cpu_pkg::*; #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int MULT_LAT = cpu_pkg::MULT_LAT
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] WRITEREG,
    input  logic [DATA_W-1:0] WRITEDATA,
    input  logic [ADDR_W-1:0] READREG1,
    input  logic [ADDR_W-1:0] READREG2,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    input  logic              MUL_START,
    input  logic [ADDR_W-1:0] MUL_SRC1,
    input  logic [ADDR_W-1:0] MUL_SRC2,
    input  logic [ADDR_W-1:0] MUL_DEST,
    output logic              MUL_BUSY,
    output logic              MUL_DONE,
    output logic [DATA_W-1:0] MULTIPLICAND,
    output logic [DATA_W-1:0] MULTIPLIER,
    input  logic [DATA_W-1:0] PRODUCT
);

    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    mul_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0] src1_data, src2_data;
    logic [DATA_W-1:0] op1_fwd, op2_fwd;
    logic              accept;
    logic              wb_we;

    reg_array_8x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regs (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .we_a    (WRITE),
        .waddr_a (WRITEREG),
        .wdata_a (WRITEDATA),
        .we_b    (wb_we),
        .waddr_b (dest_q),
        .wdata_b (PRODUCT),
        .raddr1  (READREG1),
        .raddr2  (READREG2),
        .raddr3  (MUL_SRC1),
        .raddr4  (MUL_SRC2),
        .rdata1  (REGOUT1),
        .rdata2  (REGOUT2),
        .rdata3  (src1_data),
        .rdata4  (src2_data)
    );

    // A general write in the start cycle is forwarded into the operand latch.
    assign op1_fwd = (WRITE && (WRITEREG == MUL_SRC1)) ? WRITEDATA : src1_data;
    assign op2_fwd = (WRITE && (WRITEREG == MUL_SRC2)) ? WRITEDATA : src2_data;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wb_we     = 1'b0;
        MUL_BUSY  = 1'b0;
        MUL_DONE  = 1'b0;
        case (state)
            IDLE: begin
                if (MUL_START) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                MUL_BUSY = 1'b1;
                if (cnt == '0) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                MUL_BUSY  = 1'b1;
                MUL_DONE  = 1'b1;
                wb_we     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            cnt          <= '0;
            dest_q       <= '0;
            MULTIPLICAND <= '0;
            MULTIPLIER   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt          <= CNT_W'(MULT_LAT - 1);
                dest_q       <= MUL_DEST;
                MULTIPLICAND <= op1_fwd;
                MULTIPLIER   <= op2_fwd;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_operand_stage.sv
module tb_mul_operand_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write = 1'b0;
    logic [2:0] writereg = '0;
    logic [7:0] writedata = '0;
    logic [2:0] readreg1 = '0;
    logic [2:0] readreg2 = '0;
    logic [7:0] regout1, regout2;
    logic       mul_start = 1'b0;
    logic [2:0] mul_src1 = '0;
    logic [2:0] mul_src2 = '0;
    logic [2:0] mul_dest = '0;
    logic       mul_busy, mul_done;
    logic [7:0] multiplicand, multiplier;
    logic [7:0] product;
    logic [15:0] full_prod;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural multiplier beside the stage: low 8 bits of the operand product.
    assign full_prod = 16'(multiplicand) * 16'(multiplier);
    assign product   = full_prod[7:0];

    mul_operand_stage #(
        .DATA_W   (8),
        .ADDR_W   (3),
        .MULT_LAT (2)
    ) dut (
        .CLK          (clk),
        .RESET_N      (rst_n),
        .WRITE        (write),
        .WRITEREG     (writereg),
        .WRITEDATA    (writedata),
        .READREG1     (readreg1),
        .READREG2     (readreg2),
        .REGOUT1      (regout1),
        .REGOUT2      (regout2),
        .MUL_START    (mul_start),
        .MUL_SRC1     (mul_src1),
        .MUL_SRC2     (mul_src2),
        .MUL_DEST     (mul_dest),
        .MUL_BUSY     (mul_busy),
        .MUL_DONE     (mul_done),
        .MULTIPLICAND (multiplicand),
        .MULTIPLIER   (multiplier),
        .PRODUCT      (product)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        write = 1'b1; writereg = a; writedata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        readreg1 = a;
        #1;
        d = regout1;
    endtask

    task automatic set_start(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
        mul_start = 1'b1; mul_src1 = s1; mul_src2 = s2; mul_dest = d;
    endtask

    logic [7:0] v;
    logic [5:0] busy_seq, done_seq;

    initial begin
        // 1. reset state
        #12;
        for (int i = 0; i < 8; i++) begin
            readreg1 = 3'(i);
            readreg2 = 3'(7 - i);
            #1;
            chk("reset_regout1", {8'h0, regout1}, 16'h0000);
            chk("reset_regout2", {8'h0, regout2}, 16'h0000);
        end
        chk("reset_busy", {15'h0, mul_busy}, 16'h0);
        chk("reset_done", {15'h0, mul_done}, 16'h0);
        rst_n = 1'b1;
        tick();

        // 2. basic 5 * -3
        wr(3'd1, 8'h05);
        wr(3'd2, 8'hFD);
        set_start(3'd1, 3'd2, 3'd3);
        tick();                                   // E0
        mul_start = 1'b0;
        chk("t2_mcand", {8'h0, multiplicand}, 16'h0005);
        chk("t2_mplier", {8'h0, multiplier}, 16'h00FD);
        chk("t2_busy1", {14'h0, mul_busy, mul_done}, 16'h2);
        tick();
        chk("t2_busy2", {14'h0, mul_busy, mul_done}, 16'h2);
        tick();
        chk("t2_wb", {14'h0, mul_busy, mul_done}, 16'h3);
        rd(3'd3, v);
        chk("t2_r3_before_wb", {8'h0, v}, 16'h0000);
        tick();                                   // E0+3
        chk("t2_idle", {14'h0, mul_busy, mul_done}, 16'h0);
        rd(3'd3, v);
        chk("t2_r3", {8'h0, v}, 16'h00F1);

        // 3. forwarding of a same-cycle write
        wr(3'd2, 8'h03);
        write = 1'b1; writereg = 3'd1; writedata = 8'h07;
        set_start(3'd1, 3'd2, 3'd3);
        tick();
        write = 1'b0; mul_start = 1'b0;
        chk("t3_mcand_fwd", {8'h0, multiplicand}, 16'h0007);
        tick(); tick(); tick();
        rd(3'd3, v);
        chk("t3_r3", {8'h0, v}, 16'h0015);

        // 4. start held for 6 edges: accepted at E0 and E0+4 only
        set_start(3'd1, 3'd2, 3'd5);
        for (int i = 0; i < 6; i++) begin
            tick();
            busy_seq[i] = mul_busy;
            done_seq[i] = mul_done;
        end
        mul_start = 1'b0;
        chk("t4_busy_seq", {10'h0, busy_seq}, {10'h0, 6'b110111});
        chk("t4_done_seq", {10'h0, done_seq}, {10'h0, 6'b000100});
        tick();
        chk("t4_second_wb", {14'h0, mul_busy, mul_done}, 16'h3);
        tick();
        chk("t4_idle", {14'h0, mul_busy, mul_done}, 16'h0);
        rd(3'd5, v);
        chk("t4_r5", {8'h0, v}, 16'h0015);

        // 5a. WB and general write to the same register: WB wins
        wr(3'd2, 8'h04);
        set_start(3'd1, 3'd2, 3'd3);
        tick();
        mul_start = 1'b0;
        tick(); tick();
        write = 1'b1; writereg = 3'd3; writedata = 8'hAA;
        tick();
        write = 1'b0;
        rd(3'd3, v);
        chk("t5_same_addr", {8'h0, v}, 16'h001C);

        // 5b. WB and general write to different registers: both land
        set_start(3'd1, 3'd2, 3'd6);
        tick();
        mul_start = 1'b0;
        tick(); tick();
        write = 1'b1; writereg = 3'd4; writedata = 8'hAA;
        tick();
        write = 1'b0;
        rd(3'd6, v);
        chk("t5_r6_wb", {8'h0, v}, 16'h001C);
        rd(3'd4, v);
        chk("t5_r4_write", {8'h0, v}, 16'h00AA);

        // 6. reset during WAIT aborts, then 0x7F*0x7F wraps to 0x01
        wr(3'd1, 8'h7F);
        wr(3'd2, 8'h7F);
        set_start(3'd1, 3'd2, 3'd7);
        tick();
        mul_start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_abort_state", {14'h0, mul_busy, mul_done}, 16'h0);
        chk("t6_abort_mcand", {8'h0, multiplicand}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_after_rst", {14'h0, mul_busy, mul_done}, 16'h0);
        tick();
        chk("t6_no_done", {14'h0, mul_busy, mul_done}, 16'h0);
        rd(3'd7, v);
        chk("t6_r7_cleared", {8'h0, v}, 16'h0000);
        wr(3'd1, 8'h7F);
        wr(3'd2, 8'h7F);
        set_start(3'd1, 3'd2, 3'd7);
        tick();
        mul_start = 1'b0;
        tick(); tick(); tick();
        rd(3'd7, v);
        chk("t6_wrap", {8'h0, v}, 16'h0001);

        // source equal to destination uses the old value: r1 = 0x7F*0x7F
        set_start(3'd1, 3'd2, 3'd1);
        tick();
        mul_start = 1'b0;
        chk("t7_src_is_dest", {8'h0, multiplicand}, 16'h007F);
        tick(); tick(); tick();
        rd(3'd1, v);
        chk("t7_r1", {8'h0, v}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
